// File: rtl/shreg_fsm_pkg.sv
// Shared definitions for the shreg_fsm serialiser: FSM state encoding and a
// constant-foldable ceiling-log2 used to size the bit counter.
package shreg_fsm_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Never returns less than 1 so a counter built from it always has a bit.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shreg_fsm_core.sv
// WIDTH-bit register with parallel load, one-bit shift and serial-out select.
// Load has priority over shift; the controller never asserts both at once.
module shreg_core #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             si_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             so_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (shift_i) begin
      if (MSB_FIRST != 0) begin
        q_d = {q_q[WIDTH-2:0], si_i};
      end else begin
        q_d = {si_i, q_q[WIDTH-1:1]};
      end
    end
  end

  // Falling-edge update matches the library flip-flop cell.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o  = q_q;
  assign so_o = (MSB_FIRST != 0) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: rtl/shreg_fsm.sv
// Serial/parallel shift register with bit counter and IDLE/SHIFT control FSM.
// Pulses DONE for one cycle after exactly WIDTH shifts; HOLD stalls shifting.
module shreg_fsm
  import shreg_fsm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             HOLD,
  input  logic             SI,
  output logic             SO,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE
);

  localparam int                 CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             load_en;
  logic             shift_en;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_en = LOAD;
        if (START) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (!HOLD) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  shreg_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (load_en),
    .shift_i (shift_en),
    .si_i    (SI),
    .d_i     (D),
    .q_o     (Q),
    .so_o    (SO)
  );

  assign BUSY = (state_q == ST_SHIFT);
  assign DONE = done_q;

endmodule

// File: tb/tb_shreg_fsm.sv
// Bench for shreg_fsm: MSB-first and LSB-first instances share stimulus;
// table vectors, hand-written corner sequences and a random run vs a word-level model.
module tb_shreg_fsm;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, LOAD, START, HOLD, SI;
  logic [W-1:0] D;
  logic         SO_M, SO_L, BUSY_M, BUSY_L, DONE_M, DONE_L;
  logic [W-1:0] Q_M, Q_L;

  always #5 CLK = ~CLK;

  shreg_fsm #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .D(D), .START(START), .HOLD(HOLD),
    .SI(SI), .SO(SO_M), .Q(Q_M), .BUSY(BUSY_M), .DONE(DONE_M)
  );

  shreg_fsm #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .CLK(CLK), .RST(RST), .LOAD(LOAD), .D(D), .START(START), .HOLD(HOLD),
    .SI(SI), .SO(SO_L), .Q(Q_L), .BUSY(BUSY_L), .DONE(DONE_L)
  );

  int total  = 0;
  int passed = 0;

  // Word-level reference: two words, a busy flag and the number of shifts taken.
  int mq, ml, m_busy, m_shifts, m_done;

  typedef struct {
    logic       rst, load, start, hold, si;
    logic [7:0] d, eq_m, eq_l;
    logic       eb, ed;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_edge(input logic r, l, s, h, si, input logic [7:0] d);
    if (r) begin
      mq = 0; ml = 0; m_busy = 0; m_shifts = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_busy == 0) begin
        if (l) begin mq = d; ml = d; end
        if (s) begin m_busy = 1; m_shifts = 0; end
      end else if (!h) begin
        mq = ((mq * 2) + si) % 256;
        ml = (ml / 2) + (si ? 128 : 0);
        m_shifts = m_shifts + 1;
        if (m_shifts == W) begin m_busy = 0; m_done = 1; end
      end
    end
  endtask

  task automatic step(input logic r, l, s, h, si, input logic [7:0] d);
    RST = r; LOAD = l; START = s; HOLD = h; SI = si; D = d;
    @(negedge CLK);
    #1;
    model_edge(r, l, s, h, si, d);
    chk("q_msb",    32'(Q_M),    32'(mq));
    chk("q_lsb",    32'(Q_L),    32'(ml));
    chk("so_msb",   32'(SO_M),   32'((mq / 128) % 2));
    chk("so_lsb",   32'(SO_L),   32'(ml % 2));
    chk("busy_msb", 32'(BUSY_M), 32'(m_busy));
    chk("busy_lsb", 32'(BUSY_L), 32'(m_busy));
    chk("done_msb", 32'(DONE_M), 32'(m_done));
    chk("done_lsb", 32'(DONE_L), 32'(m_done));
  endtask

  function automatic vec_t mk(input logic r, l, s, h, si, input logic [7:0] d,
                              input logic [7:0] qm, ql, input logic b, dn);
    vec_t v;
    v.rst = r; v.load = l; v.start = s; v.hold = h; v.si = si; v.d = d;
    v.eq_m = qm; v.eq_l = ql; v.eb = b; v.ed = dn;
    return v;
  endfunction

  initial begin
    int edges;
    logic [7:0] frozen;
    RST = 1'b1; LOAD = 1'b0; START = 1'b0; HOLD = 1'b0; SI = 1'b0; D = '0;

    // Load+start 0x96, SI=0: MSB SO 1,0,0,1,0,1,1,0
    tbl.push_back(mk(1,0,0,0,0,8'h00, 8'h00,8'h00,0,0));
    tbl.push_back(mk(0,1,1,0,0,8'h96, 8'h96,8'h96,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h2C,8'h4B,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h58,8'h25,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'hB0,8'h12,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h60,8'h09,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'hC0,8'h04,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h80,8'h02,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h00,8'h01,1,0));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h00,8'h00,0,1));
    tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h00,8'h00,0,0));
    // Load 0x96, then START with SI=1: LSB SO 0,1,1,0,1,0,0,1, ends 0xFF
    tbl.push_back(mk(0,1,0,0,0,8'h96, 8'h96,8'h96,0,0));
    tbl.push_back(mk(0,0,1,0,1,8'h00, 8'h96,8'h96,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'h2D,8'hCB,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'h5B,8'hE5,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'hB7,8'hF2,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'h6F,8'hF9,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'hDF,8'hFC,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'hBF,8'hFE,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'h7F,8'hFF,1,0));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'hFF,8'hFF,0,1));
    tbl.push_back(mk(0,0,0,0,1,8'h00, 8'hFF,8'hFF,0,0));

    mq = 0; ml = 0; m_busy = 0; m_shifts = 0; m_done = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      step(v.rst, v.load, v.start, v.hold, v.si, v.d);
      chk("tbl_q_msb", 32'(Q_M),    32'(v.eq_m));
      chk("tbl_q_lsb", 32'(Q_L),    32'(v.eq_l));
      chk("tbl_so_msb", 32'(SO_M),  32'(v.eq_m[7]));
      chk("tbl_so_lsb", 32'(SO_L),  32'(v.eq_l[0]));
      chk("tbl_busy",  32'(BUSY_M), 32'(v.eb));
      chk("tbl_done",  32'(DONE_M), 32'(v.ed));
    end

    // HOLD for 3 cycles after the 4th shift: DONE at START edge + 11
    step(1,0,0,0,0,8'h00);
    step(0,1,1,0,0,8'hA5);
    edges = 0;
    for (int i = 0; i < 4; i++) begin step(0,0,0,0,1'($urandom_range(0,1)),8'h00); edges++; end
    frozen = Q_M;
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,1,1'($urandom_range(0,1)),8'h00); edges++;
      chk("hold_frozen", 32'(Q_M), 32'(frozen));
    end
    while (!DONE_M && edges < 20) begin step(0,0,0,0,1'($urandom_range(0,1)),8'h00); edges++; end
    chk("hold_done_edge", 32'(edges), 32'd11);

    // START in the DONE cycle: no idle gap
    step(0,0,1,0,1,8'h00);
    chk("b2b_busy", 32'(BUSY_M), 32'd1);
    chk("b2b_done_clear", 32'(DONE_M), 32'd0);
    edges = 0;
    while (!DONE_M && edges < 20) begin step(0,0,0,0,1,8'h00); edges++; end
    chk("b2b_len", 32'(edges), 32'd8);
    chk("b2b_q", 32'(Q_M), 32'hFF);

    // Reset after the 4th shift aborts; restart completes normally
    step(0,1,1,0,0,8'h5A);
    for (int i = 0; i < 4; i++) step(0,0,0,0,1,8'h00);
    step(1,0,0,0,1,8'h00);
    chk("rst_q", 32'(Q_M), 32'd0);
    chk("rst_busy", 32'(BUSY_M), 32'd0);
    step(0,0,0,0,1,8'h00);
    chk("rst_no_done", 32'(DONE_M), 32'd0);
    step(0,0,1,0,1,8'h00);
    edges = 0;
    while (!DONE_M && edges < 20) begin step(0,0,0,0,1,8'h00); edges++; end
    chk("rst_restart_len", 32'(edges), 32'd8);
    chk("rst_restart_qm", 32'(Q_M), 32'hFF);
    chk("rst_restart_ql", 32'(Q_L), 32'hFF);

    // LOAD/START during SHIFT are ignored
    step(0,1,1,0,0,8'h3C);
    edges = 0;
    for (int i = 0; i < 2; i++) begin step(0,0,0,0,0,8'h00); edges++; end
    step(0,1,1,0,0,8'hFF); edges++;
    while (!DONE_M && edges < 20) begin step(0,0,0,0,0,8'h00); edges++; end
    chk("ign_len", 32'(edges), 32'd8);
    chk("ign_q", 32'(Q_M), 32'h00);

    // Random run against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0,49) == 0), ($urandom_range(0,3) == 0),
           ($urandom_range(0,3) == 0), ($urandom_range(0,3) == 0),
           1'($urandom_range(0,1)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
